fetch_prefetch_unit: RTL and testbench
======================================

Name: fetch_prefetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the decode/control path.
- Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words with their PCs in a small prefetch queue and presents them to the consumer with valid/ready.
- Accepts PC redirects for branch, jump, jal and jr targets: flushes buffered work and discards any stale in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset; bits [1:0] must be 0.
- DEPTH, 4, prefetch queue entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  read request; held until acknowledged
- imem_addr  out  32  word address of the request; stable while imem_req=1
- imem_ack  in  1  one-cycle pulse: imem_rdata valid, request complete
- imem_rdata  in  32  instruction word returned with imem_ack
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  32  new fetch target; bits [1:0] ignored (forced to 0)
- instr_valid  out  1  queue head valid
- instr_ready  in  1  consumer accepts head this cycle
- instr  out  32  queue head instruction word
- instr_pc  out  32  address of the queue head
- instr_pc4  out  32  instr_pc+4 (feeds link/branch-base logic)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset, sampled on the rising edge of clk, and overrides every other input, including a reset asserted mid-request.
- Reset values:
  - fetch_pc=RESET_PC, queue empty, state=IDLE.
  - imem_req=0, instr_valid=0.
  - imem_addr=RESET_PC, instr=0, instr_pc=0, instr_pc4=4.
- State machine:
  - IDLE: no request outstanding. Go to WAIT when the issue condition holds (below).
  - WAIT: request outstanding. On imem_ack with no redirect, push {fetch_pc, imem_rdata}, advance fetch_pc by 4, then go to IDLE.
  - DROP: stale request outstanding after a redirect. On imem_ack, discard the data and go to IDLE.
- Issue condition: the block enters WAIT when state=IDLE, no redirect this cycle, and the queue occupancy after this cycle's pop is below DEPTH. imem_req is high from the cycle after that decision.
- Handshake rules:
  - imem_req=1 exactly in WAIT and DROP.
  - imem_addr=fetch_pc in WAIT, and the latched stale address in DROP. It never changes while imem_req=1.
  - imem_ack is legal in any cycle with imem_req=1, including the first. An ack while imem_req=0 is ignored.
  - Minimum issue-to-push latency is 2 cycles (1 cycle to leave IDLE, ack in the first WAIT cycle). Peak throughput is one word per 2 cycles; this is decided and no back-to-back requests are made.
- Queue:
  - FIFO of DEPTH entries, each {pc[31:0], word[31:0]}.
  - Head is shown combinationally on instr, instr_pc and instr_pc4; instr_valid is 1 when not empty.
  - A pop occurs when instr_valid && instr_ready.
  - Push and pop in the same cycle are both performed.
  - Overflow is impossible by the issue rule. At most one request is outstanding, so the occupancy check reserves its slot.
  - Pop while empty has no effect.
- Redirect (redirect_valid=1):
  - Queue flushed; a same-cycle pop is ignored (the consumer observes instr_valid=0 next cycle).
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - In WAIT without ack: go to DROP; imem_addr keeps the old address until ack. The request is never aborted.
  - In WAIT or DROP with ack in the same cycle: data discarded, go to IDLE.
  - In IDLE: stay IDLE, and issue the next cycle.
  - A redirect in DROP with no ack updates fetch_pc and stays in DROP.
- Arithmetic: fetch_pc+4 and instr_pc+4 are modulo 2^32, so 32'hFFFF_FFFC wraps to 0. There is no alignment fault.
- Outputs when instr_valid=0: instr, instr_pc and instr_pc4 hold their last values; the consumer must not use them.

Decomposition:
- Shared package holds:
  - the state enum {IDLE, WAIT, DROP};
  - WORD_W=32;
  - PC_STEP=4;
  - the default RESET_PC.
- One natural sub-module, fetch_queue: a synchronous FIFO with parameter DEPTH and 64-bit entries. It provides push, pop, flush, head and count, with flush taking priority over push and pop.

Test Plan:
- Reset, memory acks every first WAIT cycle, instr_ready=1 -> imem_addr sequence 0,4,8,...; instr/instr_pc pairs match memory; one word every 2 cycles.
- instr_ready=0, DEPTH=4 -> exactly 4 acks accepted, then imem_req stays 0 with queue full. Raise ready -> pop order is PCs 0,4,8,12 and fetch resumes at 16.
- Ack delayed 5 cycles with redirect_pc=0x100 in cycle 2 of WAIT -> imem_addr held at the old PC until ack; its word is never presented; next request is 0x100; first instr_pc=0x100.
- Redirect and pop in the same cycle with 3 entries queued; redirect_pc=0x203 -> instr_valid=0 next cycle; fetch at 0x200.
- RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; instr_pc4 of FFFF_FFFC is 0.
- reset asserted while in WAIT, then ack arrives during reset -> ack ignored; after reset imem_req=0, instr_valid=0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_prefetch_unit_pkg;

  localparam int          WORD_W           = 32;
  localparam int          ENTRY_W          = 2 * WORD_W;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // IDLE: nothing outstanding; WAIT: live request; DROP: stale request after a redirect
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  // Word-align a fetch target by clearing the byte-offset bits
  function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_prefetch_unit_queue.sv
// Small synchronous FIFO of {pc, word} entries with flush. The head is shown
// combinationally; while empty it keeps showing the last head that was visible.
module fetch_queue
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [ENTRY_W-1:0]       head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [ENTRY_W-1:0] hold_reg;
  logic [ENTRY_W-1:0] entries [DEPTH];
  logic               wr_en;
  logic               rd_en;

  assign empty = (count_reg == '0);
  assign count = count_reg;
  // Flush wins over both push and pop; popping an empty queue does nothing
  assign wr_en = push && !flush;
  assign rd_en = pop && !empty && !flush;
  assign head  = empty ? hold_reg : entries[rd_ptr_reg];

  // One storage register per slot, written only when the write pointer selects it
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [ENTRY_W-1:0] entry_reg;

    // Capture the pushed entry into this slot
    always_ff @(posedge clk) begin
      if (wr_en && (wr_ptr_reg == PTR_W'(gi))) begin
        entry_reg <= push_data;
      end
    end

    assign entries[gi] = entry_reg;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  // Remember the visible head so outputs stay put once the queue drains or flushes
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_reg <= '0;
    end else if (!empty) begin
      hold_reg <= entries[rd_ptr_reg];
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: owns the fetch PC, issues one word read at a time, buffers
// returned words with their PCs and handles redirects by flushing and dropping
// any stale in-flight response.
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc4
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e       state_reg;
  logic [31:0]        fetch_pc_reg;
  logic               req_reg;
  logic [31:0]        addr_reg;

  logic [ENTRY_W-1:0] q_head;
  logic [CNT_W-1:0]   q_count;
  logic               q_empty;
  logic               q_push;
  logic               pop;
  logic               issue;
  logic [31:0]        redirect_target;

  assign redirect_target = align_pc(redirect_pc);
  assign instr_valid     = !q_empty;
  assign pop             = instr_valid && instr_ready;

  // Only issue when the slot for the returning word is guaranteed free after this cycle's pop
  assign issue  = (state_reg == IDLE) && !redirect_valid &&
                  ((q_count - CNT_W'(pop)) < CNT_W'(DEPTH));
  assign q_push = (state_reg == WAIT) && imem_ack && !redirect_valid;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data ({fetch_pc_reg, imem_rdata}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (q_head),
    .count     (q_count),
    .empty     (q_empty)
  );

  assign instr     = q_head[WORD_W-1:0];
  assign instr_pc  = q_head[ENTRY_W-1:WORD_W];
  assign instr_pc4 = instr_pc + PC_STEP;
  assign imem_req  = req_reg;
  assign imem_addr = addr_reg;

  // Fetch FSM; the request address is latched at issue and never touched while outstanding
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      req_reg      <= 1'b0;
      addr_reg     <= RESET_PC;
    end else begin
      case (state_reg)
        IDLE: begin
          if (redirect_valid) begin
            fetch_pc_reg <= redirect_target;
          end else if (issue) begin
            state_reg <= WAIT;
            req_reg   <= 1'b1;
            addr_reg  <= fetch_pc_reg;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            state_reg    <= IDLE;
            req_reg      <= 1'b0;
            fetch_pc_reg <= redirect_valid ? redirect_target : fetch_pc_reg + PC_STEP;
          end else if (redirect_valid) begin
            // Request cannot be aborted; wait out its ack and throw the data away
            state_reg    <= DROP;
            fetch_pc_reg <= redirect_target;
          end
        end
        DROP: begin
          if (redirect_valid) begin
            fetch_pc_reg <= redirect_target;
          end
          if (imem_ack) begin
            state_reg <= IDLE;
            req_reg   <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          req_reg   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: memory responder plus scoreboard.
module tb_fetch_prefetch_unit;
  import fetch_prefetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc4;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc4      (instr_pc4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  // scoreboard and model state
  logic [63:0] sb[$];
  logic [63:0] pop_log[$];
  logic [31:0] model_pc;
  logic [31:0] req_addr_lat;
  logic [31:0] redir_pc_cfg;
  bit          stale, req_prev, ready_cfg, rst_cfg, redir_cfg, rate_chk;
  int          wait_cnt, ack_delay, ack_count, drop_count, cycle_no, last_rise;

  // One clock: sample at posedge+1, drive inputs, update model, advance
  task automatic do_cycle();
    bit          ack;
    bit          pop;
    logic [63:0] exp;
    logic [31:0] exp_pc4;
    ack = 1'b0;
    check_eq("instr_valid", {63'd0, instr_valid}, {63'd0, (sb.size() != 0)});
    pop = instr_valid && ready_cfg && !rst_cfg;
    if (pop && sb.size() != 0) begin
      exp     = sb[0];
      exp_pc4 = exp[63:32] + 32'd4;
      check_eq("head_pc", {32'd0, instr_pc}, {32'd0, exp[63:32]});
      check_eq("head_word", {32'd0, instr}, {32'd0, exp[31:0]});
      check_eq("head_pc4", {32'd0, instr_pc4}, {32'd0, exp_pc4});
      $display("pop  pc=%h word=%h pc4=%h", instr_pc, instr, instr_pc4);
      pop_log.push_back({instr_pc, instr_pc4});
    end
    if (imem_req) begin
      if (!req_prev) begin
        wait_cnt     = 0;
        req_addr_lat = imem_addr;
        $display("req  addr=%h stale=%0d", imem_addr, stale);
        if (!stale) check_eq("req_addr", {32'd0, imem_addr}, {32'd0, model_pc});
        if (rate_chk && last_rise >= 0)
          check_eq("issue_period", 64'(cycle_no - last_rise), 64'd2);
        last_rise = cycle_no;
      end else begin
        check_eq("addr_hold", {32'd0, imem_addr}, {32'd0, req_addr_lat});
      end
      if (wait_cnt >= ack_delay) ack = 1'b1;
      else wait_cnt++;
    end
    reset          = rst_cfg;
    imem_ack       = ack;
    imem_rdata     = ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    instr_ready    = ready_cfg;
    redirect_valid = redir_cfg;
    redirect_pc    = redir_pc_cfg;
    if (rst_cfg) begin
      sb.delete();
      model_pc = 32'h0000_0000;
      stale    = 1'b0;
    end else begin
      if (pop && sb.size() != 0) sb.delete(0);
      if (ack) begin
        if (!stale && !redir_cfg) begin
          sb.push_back({model_pc, mem_word(model_pc)});
          model_pc = model_pc + 32'd4;
          ack_count++;
        end else begin
          drop_count++;
        end
        stale = 1'b0;
      end
      if (redir_cfg) begin
        sb.delete();
        model_pc = redir_pc_cfg & 32'hFFFF_FFFC;
        if (imem_req && !ack) stale = 1'b1;
      end
    end
    req_prev = imem_req;
    @(posedge clk);
    #1;
    cycle_no++;
    redir_cfg = 1'b0;
  endtask

  task automatic apply_reset();
    rst_cfg = 1'b1;
    do_cycle();
    do_cycle();
    rst_cfg   = 1'b0;
    ack_count = 0;
  endtask

  task automatic wait_rise(input int budget);
    int k = 0;
    while (!(imem_req && !req_prev) && k < budget) begin
      do_cycle();
      k++;
    end
    if (!(imem_req && !req_prev)) check_eq("timeout_req", 64'd0, 64'd1);
  endtask

  task automatic run_until_pops(input int n, input int budget);
    int k = 0;
    while (pop_log.size() < n && k < budget) begin
      do_cycle();
      k++;
    end
    if (pop_log.size() < n) check_eq("timeout_pops", 64'(pop_log.size()), 64'(n));
  endtask

  initial begin
    int k;
    int drops_before;
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; redirect_valid = 1'b0;
    redirect_pc = '0; instr_ready = 1'b0;
    ready_cfg = 1'b0; rst_cfg = 1'b1; redir_cfg = 1'b0; redir_pc_cfg = '0;
    stale = 1'b0; req_prev = 1'b0; rate_chk = 1'b0; model_pc = '0; req_addr_lat = '0;
    wait_cnt = 0; ack_delay = 0; ack_count = 0; drop_count = 0; cycle_no = 0; last_rise = -1;
    @(posedge clk);
    #1;

    // reset state
    apply_reset();
    check_eq("rst_req", {63'd0, imem_req}, 64'd0);
    check_eq("rst_valid", {63'd0, instr_valid}, 64'd0);
    check_eq("rst_addr", {32'd0, imem_addr}, 64'h0);
    check_eq("rst_instr", {32'd0, instr}, 64'h0);
    check_eq("rst_pc", {32'd0, instr_pc}, 64'h0);
    check_eq("rst_pc4", {32'd0, instr_pc4}, 64'h4);

    // streaming: immediate ack, consumer always ready, one request every 2 cycles
    ready_cfg = 1'b1; ack_delay = 0; rate_chk = 1'b1; last_rise = -1;
    pop_log.delete();
    for (k = 0; k < 20; k++) do_cycle();
    rate_chk = 1'b0;
    run_until_pops(3, 20);
    if (pop_log.size() >= 3) begin
      check_eq("stream_pc0", {32'd0, pop_log[0][63:32]}, 64'h0);
      check_eq("stream_pc1", {32'd0, pop_log[1][63:32]}, 64'h4);
      check_eq("stream_pc2", {32'd0, pop_log[2][63:32]}, 64'h8);
    end

    // consumer stalled: queue fills to DEPTH, then drains in order
    ready_cfg = 1'b0;
    apply_reset();
    for (k = 0; k < 30; k++) do_cycle();
    check_eq("full_acks", 64'(ack_count), 64'd4);
    check_eq("full_req_low", {63'd0, imem_req}, 64'd0);
    check_eq("full_valid", {63'd0, instr_valid}, 64'd1);
    ready_cfg = 1'b1;
    pop_log.delete();
    wait_rise(20);
    check_eq("resume_addr", {32'd0, imem_addr}, 64'h10);
    run_until_pops(4, 40);
    if (pop_log.size() >= 4) begin
      check_eq("drain_pc0", {32'd0, pop_log[0][63:32]}, 64'h0);
      check_eq("drain_pc1", {32'd0, pop_log[1][63:32]}, 64'h4);
      check_eq("drain_pc2", {32'd0, pop_log[2][63:32]}, 64'h8);
      check_eq("drain_pc3", {32'd0, pop_log[3][63:32]}, 64'hC);
    end

    // redirect during a slow request: old request completes, data dropped
    ack_delay = 5;
    wait_rise(20);
    req_addr_lat = imem_addr;
    do_cycle();
    drops_before = drop_count;
    redir_cfg = 1'b1; redir_pc_cfg = 32'h0000_0100;
    do_cycle();
    pop_log.delete();
    check_eq("drop_addr_held", {32'd0, imem_addr}, {32'd0, req_addr_lat});
    check_eq("drop_req_high", {63'd0, imem_req}, 64'd1);
    run_until_pops(1, 60);
    check_eq("drop_count", 64'(drop_count - drops_before), 64'd1);
    if (pop_log.size() >= 1) check_eq("redir_first_pc", {32'd0, pop_log[0][63:32]}, 64'h100);

    // redirect with a same-cycle pop and 3 entries queued
    ready_cfg = 1'b0; ack_delay = 0;
    k = 0;
    while (sb.size() != 3 && k < 40) begin
      do_cycle();
      k++;
    end
    check_eq("three_queued", 64'(sb.size()), 64'd3);
    ready_cfg = 1'b1; redir_cfg = 1'b1; redir_pc_cfg = 32'h0000_0203;
    do_cycle();
    check_eq("flush_valid", {63'd0, instr_valid}, 64'd0);
    pop_log.delete();
    run_until_pops(1, 40);
    if (pop_log.size() >= 1) check_eq("flush_first_pc", {32'd0, pop_log[0][63:32]}, 64'h200);

    // wrap of the PC past the top of the address space
    redir_cfg = 1'b1; redir_pc_cfg = 32'hFFFF_FFF8;
    do_cycle();
    pop_log.delete();
    run_until_pops(3, 40);
    if (pop_log.size() >= 3) begin
      check_eq("wrap_pc0", {32'd0, pop_log[0][63:32]}, 64'hFFFF_FFF8);
      check_eq("wrap_pc1", {32'd0, pop_log[1][63:32]}, 64'hFFFF_FFFC);
      check_eq("wrap_pc4", {32'd0, pop_log[1][31:0]}, 64'h0);
      check_eq("wrap_pc2", {32'd0, pop_log[2][63:32]}, 64'h0);
    end

    // reset while a request is outstanding, with the ack landing during reset
    ack_delay = 100;
    wait_rise(20);
    do_cycle();
    ack_delay = 1;
    rst_cfg   = 1'b1;
    do_cycle();
    rst_cfg   = 1'b0;
    ack_count = 0;
    check_eq("wrst_req", {63'd0, imem_req}, 64'd0);
    check_eq("wrst_valid", {63'd0, instr_valid}, 64'd0);
    ack_delay = 0;
    wait_rise(10);
    check_eq("wrst_addr", {32'd0, imem_addr}, 64'h0);
    pop_log.delete();
    run_until_pops(2, 20);
    if (pop_log.size() >= 2) begin
      check_eq("wrst_pc0", {32'd0, pop_log[0][63:32]}, 64'h0);
      check_eq("wrst_pc1", {32'd0, pop_log[1][63:32]}, 64'h4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
